// File: rtl/ucsbece154b_line_fill.sv
// ucsbece154b_line_fill
// Drains BLOCK_WORDS words from a registered-output FIFO after a fill
// request and assembles them into one cache line, critical word first,
// wrapping from the requested word offset. The finished line is offered
// through a valid/ready handshake.
//
// Optional build macro LINEFILL_CWF_EN adds crit_word_o / crit_valid_o,
// which forward the critical word one cycle after it is captured.
module ucsbece154b_line_fill #(
   parameter  int unsigned DATA_WIDTH   = 32,
   parameter  int unsigned BLOCK_WORDS  = 4,
   localparam int unsigned OFFSET_WIDTH = $clog2(BLOCK_WORDS)
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              start_i,
   input  logic [OFFSET_WIDTH-1:0]           word_offset_i,
   output logic                              busy_o,
   input  logic [DATA_WIDTH-1:0]             fifo_data_i,
   input  logic                              fifo_valid_i,
   output logic                              fifo_pop_o,
   output logic [DATA_WIDTH*BLOCK_WORDS-1:0] line_o,
   output logic                              line_valid_o,
   input  logic                              line_ready_i
`ifdef LINEFILL_CWF_EN
   ,
   output logic [DATA_WIDTH-1:0]             crit_word_o,
   output logic                              crit_valid_o
`endif
);

   // Counters need one extra bit so they can hold BLOCK_WORDS itself.
   localparam logic [OFFSET_WIDTH:0] BW_CNT   = (OFFSET_WIDTH+1)'(BLOCK_WORDS);
   localparam logic [OFFSET_WIDTH:0] LAST_CNT = (OFFSET_WIDTH+1)'(BLOCK_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                                    state_q, state_d;
   logic [OFFSET_WIDTH:0]                     issue_cnt_q;
   logic [OFFSET_WIDTH:0]                     recv_cnt_q;
   logic                                      pop_q;
   logic [OFFSET_WIDTH-1:0]                   offset_q;
   logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0]    line_q;
   logic                                      capture;
   logic                                      accept;
   logic [OFFSET_WIDTH-1:0]                   wr_idx;

   assign line_o = line_q;

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode plus handshake and FIFO pop outputs.
   always_comb begin
      state_d      = state_q;
      busy_o       = 1'b0;
      fifo_pop_o   = 1'b0;
      line_valid_o = 1'b0;
      accept       = 1'b0;
      capture      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               accept  = 1'b1;
               state_d = FILL;
            end
         end
         FILL: begin
            busy_o     = 1'b1;
            fifo_pop_o = fifo_valid_i && (issue_cnt_q < BW_CNT);
            capture    = pop_q;
            if (pop_q && (recv_cnt_q == LAST_CNT)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            busy_o       = 1'b1;
            line_valid_o = 1'b1;
            if (line_ready_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Destination slot wraps naturally in OFFSET_WIDTH bits.
   always_comb begin
      wr_idx = offset_q + recv_cnt_q[OFFSET_WIDTH-1:0];
   end

   // Pop/receive bookkeeping and line assembly.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         issue_cnt_q <= '0;
         recv_cnt_q  <= '0;
         pop_q       <= 1'b0;
         offset_q    <= '0;
         line_q      <= '0;
      end else begin
         pop_q <= fifo_pop_o && fifo_valid_i;
         if (accept) begin
            offset_q    <= word_offset_i;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
         end
         if (fifo_pop_o) begin
            issue_cnt_q <= issue_cnt_q + 1'b1;
         end
         if (capture) begin
            line_q[wr_idx] <= fifo_data_i;
            recv_cnt_q     <= recv_cnt_q + 1'b1;
         end
      end
   end

`ifdef LINEFILL_CWF_EN
   // Forward the first captured (critical) word with a one-cycle strobe.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         crit_word_o  <= '0;
         crit_valid_o <= 1'b0;
      end else begin
         crit_valid_o <= capture && (recv_cnt_q == '0);
         if (capture && (recv_cnt_q == '0)) begin
            crit_word_o <= fifo_data_i;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ucsbece154b_line_fill.sv
// Directed bench for ucsbece154b_line_fill with a behavioural
// registered-output FIFO feeding the DUT.
module tb_ucsbece154b_line_fill;

   localparam int DW = 32;
   localparam int BW = 4;
   localparam int LW = DW * BW;

   logic          clk = 1'b0;
   logic          rst_ni;
   logic          start;
   logic [1:0]    word_offset;
   logic          busy;
   logic [DW-1:0] fifo_data;
   logic          fifo_valid;
   logic          fifo_pop;
   logic [LW-1:0] line;
   logic          line_valid;
   logic          line_ready;
`ifdef LINEFILL_CWF_EN
   logic [DW-1:0] crit_word;
   logic          crit_valid;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   // FIFO model storage: head advances on pop, tail advances on push.
   logic [DW-1:0] mem [0:63];
   int            head = 0;
   int            tail = 0;
   int            pops = 0;
   int            p0;
   logic [LW-1:0] held;

   always #5 clk = ~clk;

   assign fifo_valid = (head != tail);

   // Registered FIFO data output: word appears the cycle after the pop.
   always @(posedge clk) begin
      if (fifo_pop && fifo_valid) begin
         fifo_data <= mem[head];
         head      <= head + 1;
         pops      <= pops + 1;
      end
   end

   ucsbece154b_line_fill #(
      .DATA_WIDTH (DW),
      .BLOCK_WORDS(BW)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .start_i      (start),
      .word_offset_i(word_offset),
      .busy_o       (busy),
      .fifo_data_i  (fifo_data),
      .fifo_valid_i (fifo_valid),
      .fifo_pop_o   (fifo_pop),
      .line_o       (line),
      .line_valid_o (line_valid),
      .line_ready_i (line_ready)
`ifdef LINEFILL_CWF_EN
      ,
      .crit_word_o  (crit_word),
      .crit_valid_o (crit_valid)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] v);
      mem[tail] = v;
      tail      = tail + 1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chkl(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [1:0] off);
      start       = 1'b1;
      word_offset = off;
      tick();
      start       = 1'b0;
   endtask

   task automatic wait_valid(input int max);
      for (int i = 0; i < max; i++) begin
         if (line_valid) break;
         tick();
      end
      chk1("line_valid_wait", line_valid, 1'b1);
   endtask

   task automatic handshake();
      line_ready = 1'b1;
      tick();
      line_ready = 1'b0;
      chk1("hs_valid_low", line_valid, 1'b0);
      chk1("hs_busy_low", busy, 1'b0);
   endtask

   initial begin
      rst_ni      = 1'b0;
      start       = 1'b0;
      word_offset = 2'd0;
      line_ready  = 1'b0;
      tick();
      tick();
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_pop", fifo_pop, 1'b0);
      chk1("rst_valid", line_valid, 1'b0);
      chkl("rst_line", line, '0);
      rst_ni = 1'b1;
      tick();

      // Basic fill, offset 0, FIFO continuously valid.
      push(32'hA0); push(32'hA1); push(32'hA2); push(32'hA3);
      chk1("idle_no_pop", fifo_pop, 1'b0);
      p0 = pops;
      do_start(2'd0);
      for (int c = 1; c <= 5; c++) begin
         chk1($sformatf("basic_pop_c%0d", c), fifo_pop, (c <= 4));
         chk1($sformatf("basic_busy_c%0d", c), busy, 1'b1);
         chk1($sformatf("basic_nvalid_c%0d", c), line_valid, 1'b0);
         tick();
      end
      chk1("basic_valid_c6", line_valid, 1'b1);
      chkl("basic_line", line, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
      chki("basic_pops", pops - p0, 4);
      tick();
      tick();
      chk1("basic_hold_valid", line_valid, 1'b1);
      chkl("basic_hold_line", line, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
      handshake();

      // Wrap from offset 2.
      push(32'hB0); push(32'hB1); push(32'hB2); push(32'hB3);
      do_start(2'd2);
      wait_valid(10);
      chkl("wrap_line", line, {32'hB1, 32'hB0, 32'hB3, 32'hB2});
      handshake();

      // Starvation: two words, FIFO empty for five cycles, two more words.
      push(32'hD0); push(32'hD1);
      p0 = pops;
      do_start(2'd1);
      chk1("starve_pop_c1", fifo_pop, 1'b1);
      tick();
      chk1("starve_pop_c2", fifo_pop, 1'b1);
      tick();
      for (int c = 3; c <= 7; c++) begin
         chk1($sformatf("starve_fvalid_c%0d", c), fifo_valid, 1'b0);
         chk1($sformatf("starve_nopop_c%0d", c), fifo_pop, 1'b0);
         chk1($sformatf("starve_busy_c%0d", c), busy, 1'b1);
         chk1($sformatf("starve_nvalid_c%0d", c), line_valid, 1'b0);
         tick();
      end
      push(32'hD2); push(32'hD3);
      wait_valid(10);
      chkl("starve_line", line, {32'hD2, 32'hD1, 32'hD0, 32'hD3});
      chki("starve_pops", pops - p0, 4);

      // DONE with start held high and FIFO valid: nothing moves.
      push(32'hE0); push(32'hE1); push(32'hE2); push(32'hE3);
      held        = line;
      start       = 1'b1;
      word_offset = 2'd0;
      for (int c = 0; c < 3; c++) begin
         chk1($sformatf("ign_valid_%0d", c), line_valid, 1'b1);
         chkl($sformatf("ign_line_%0d", c), line, held);
         chk1($sformatf("ign_nopop_%0d", c), fifo_pop, 1'b0);
         tick();
      end
      line_ready = 1'b1;
      tick();
      line_ready = 1'b0;
      chk1("ign_idle_valid", line_valid, 1'b0);
      chk1("ign_idle_busy", busy, 1'b0);
      p0 = pops;
      tick();
      start = 1'b0;
      chk1("ign_accept_busy", busy, 1'b1);
      chk1("ign_accept_pop", fifo_pop, 1'b1);
      tick();
      tick();

      // Reset mid-fill after two pops.
      chki("midrst_pops", pops - p0, 2);
      rst_ni = 1'b0;
      #1;
      chk1("midrst_busy", busy, 1'b0);
      chk1("midrst_pop", fifo_pop, 1'b0);
      chk1("midrst_valid", line_valid, 1'b0);
      chkl("midrst_line", line, '0);
      tick();
      rst_ni = 1'b1;
      tick();
      push(32'hF0); push(32'hF1);
      do_start(2'd0);
      wait_valid(10);
      chkl("midrst_refill", line, {32'hF1, 32'hF0, 32'hE3, 32'hE2});
      handshake();

`ifdef LINEFILL_CWF_EN
      // Critical word forwarding, offset 3.
      push(32'hC0); push(32'hC1); push(32'hC2); push(32'hC3);
      do_start(2'd3);
      chk1("cwf_c1", crit_valid, 1'b0);
      tick();
      chk1("cwf_c2", crit_valid, 1'b0);
      tick();
      chk1("cwf_c3_valid", crit_valid, 1'b1);
      chkl("cwf_c3_word", LW'(crit_word), LW'(32'hC0));
      chk1("cwf_c3_nline", line_valid, 1'b0);
      tick();
      chk1("cwf_c4", crit_valid, 1'b0);
      wait_valid(10);
      chkl("cwf_line", line, {32'hC0, 32'hC3, 32'hC2, 32'hC1});
      handshake();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
